// File: rtl/mux_pkg.sv
// Shared types and helpers for the handshaked arbitrating mux.
package mux_pkg;

    typedef enum logic [1:0] {
        ARB_SELECT,
        ARB_FIXED,
        ARB_RR
    } arb_mode_t;

    localparam int unsigned MAX_ONEHOT = 256;
    localparam int unsigned IDX_W      = 8;

    // Binary index of a one-hot vector; zero when no bit is set.
    function automatic logic [IDX_W-1:0] onehot_to_bin(input logic [MAX_ONEHOT-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_ONEHOT; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned SIZE = 3
) (
    input  logic [(2**SIZE)-1:0] req,
    input  logic [SIZE-1:0]      ptr,
    output logic [(2**SIZE)-1:0] grant
);

    localparam int unsigned CHANNELS = 2**SIZE;

    logic [CHANNELS-1:0]   rot;
    logic [CHANNELS-1:0]   pick;
    logic [2*CHANNELS-1:0] grant_dbl;

    // Rotate ptr down to bit 0, isolate lowest request, rotate back.
    always_comb begin
        rot       = CHANNELS'({req, req} >> ptr);
        pick      = rot & (~rot + CHANNELS'(1));
        grant_dbl = {pick, pick} << ptr;
        grant     = CHANNELS'(grant_dbl >> CHANNELS);
    end

endmodule

// File: rtl/arb_mux.sv
// Valid/ready N:1 arbitrating mux with a single-entry output register.
module arb_mux
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned SIZE  = 3,
    parameter arb_mode_t   MODE  = ARB_RR
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [(2**SIZE)*WIDTH-1:0]    in,
    input  logic [(2**SIZE)-1:0]          in_valid,
    output logic [(2**SIZE)-1:0]          in_ready,
    input  logic [SIZE-1:0]               select,
    output logic [WIDTH-1:0]              out,
    output logic [SIZE-1:0]               out_chan,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int unsigned CHANNELS = 2**SIZE;

    logic [SIZE-1:0]     ptr;
    logic [SIZE-1:0]     arb_ptr;
    logic [SIZE-1:0]     grant_idx;
    logic [CHANNELS-1:0] arb_grant;
    logic [CHANNELS-1:0] sel_grant;
    logic [CHANNELS-1:0] grant;
    logic [WIDTH-1:0]    word;
    logic                take;

    // Fixed priority is round-robin anchored at channel 0.
    assign arb_ptr = (MODE == ARB_RR) ? ptr : '0;

    rr_arbiter #(
        .SIZE (SIZE)
    ) u_arb (
        .req   (in_valid),
        .ptr   (arb_ptr),
        .grant (arb_grant)
    );

    always_comb begin
        sel_grant         = '0;
        sel_grant[select] = in_valid[select];
        grant             = (MODE == ARB_SELECT) ? sel_grant : arb_grant;
        take              = !out_valid || out_ready;
        in_ready          = (reset && take) ? grant : '0;
        grant_idx         = SIZE'(onehot_to_bin(MAX_ONEHOT'(grant)));
        word              = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                word = word | in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register refills whenever it is empty or draining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out       <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (take) begin
            if (|grant) begin
                out       <= word;
                out_chan  <= grant_idx;
                out_valid <= 1'b1;
                if (MODE == ARB_RR) begin
                    ptr <= grant_idx + SIZE'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: one instance per mode, directed table plus random vs. model.
module tb_arb_mux;
    import mux_pkg::*;

    localparam int W = 3;
    localparam int S = 3;
    localparam int C = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [C*W-1:0] in;
    logic [C-1:0]   in_valid;
    logic [S-1:0]   select;
    logic           out_ready;

    logic [C-1:0]   ready_d [3];
    logic [W-1:0]   out_d   [3];
    logic [S-1:0]   chan_d  [3];
    logic           valid_d [3];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 3; d++) begin : g_dut
        arb_mux #(
            .WIDTH (W),
            .SIZE  (S),
            .MODE  (arb_mode_t'(d))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in        (in),
            .in_valid  (in_valid),
            .in_ready  (ready_d[d]),
            .select    (select),
            .out       (out_d[d]),
            .out_chan  (chan_d[d]),
            .out_valid (valid_d[d]),
            .out_ready (out_ready)
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state per mode instance (0 select, 1 fixed, 2 round-robin).
    int m_valid [3];
    int m_out   [3];
    int m_chan  [3];
    int m_ptr   [3];

    typedef struct {
        logic       rst;
        logic [7:0] valid;
        logic [2:0] sel;
        logic       ordy;
        int         dut;
        logic       ev;
        logic [2:0] eo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 0; m_out[d] = 0; m_chan[d] = 0; m_ptr[d] = 0;
        end
    endtask

    // Winning channel under the current inputs, or -1.
    function automatic int pick(input int d, input int ptr);
        if (d == 0) return in_valid[select] ? int'(select) : -1;
        for (int k = 0; k < C; k++) begin
            int idx;
            idx = (d == 2) ? (ptr + k) % C : k;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic apply(input logic rst, input logic [7:0] v, input logic [2:0] sel, input logic ordy);
        reset = rst; in_valid = v; select = sel; out_ready = ordy;
        if (!rst) model_reset();
    endtask

    // Check combinational readies, advance one clock, check registered outputs.
    task automatic step();
        int g [3];
        int take [3];
        int exp_rdy;
        #1;
        for (int d = 0; d < 3; d++) begin
            g[d] = pick(d, m_ptr[d]);
            take[d] = (m_valid[d] == 0 || out_ready) ? 1 : 0;
            exp_rdy = (reset && take[d] != 0 && g[d] >= 0) ? (1 << g[d]) : 0;
            chk($sformatf("in_ready[m%0d]", d), int'(ready_d[d]), exp_rdy);
            chk($sformatf("ready_onehot[m%0d]", d), ($countones(ready_d[d]) <= 1) ? 1 : 0, 1);
        end
        @(posedge clk);
        if (reset) begin
            for (int d = 0; d < 3; d++) begin
                if (take[d] != 0) begin
                    if (g[d] >= 0) begin
                        m_valid[d] = 1;
                        m_out[d]   = int'(in[g[d]*W +: W]);
                        m_chan[d]  = g[d];
                        if (d == 2) m_ptr[d] = (g[d] + 1) % C;
                    end else begin
                        m_valid[d] = 0;
                    end
                end
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("out_valid[m%0d]", d), int'(valid_d[d]), m_valid[d]);
            chk($sformatf("out[m%0d]", d), int'(out_d[d]), m_out[d]);
            chk($sformatf("out_chan[m%0d]", d), int'(chan_d[d]), m_chan[d]);
        end
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].valid, vecs[i].sel, vecs[i].ordy);
            step();
            chk($sformatf("vec%0d_valid", i), int'(valid_d[vecs[i].dut]), int'(vecs[i].ev));
            chk($sformatf("vec%0d_out", i), int'(out_d[vecs[i].dut]), int'(vecs[i].eo));
        end
        vecs.delete();
    endtask

    initial begin
        for (int i = 0; i < C; i++) in[i*W +: W] = W'(i);
        model_reset();
        apply(1'b0, 8'hFF, 3'd0, 1'b1);
        @(negedge clk);

        // Reset held, then round-robin over all channels.
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 8'hFF, 3'd0, 1'b1, 2, 1'b0, 3'd0});
        for (int i = 0; i < 10; i++) vecs.push_back('{1'b1, 8'hFF, 3'd0, 1'b1, 2, 1'b1, 3'(i % 8)});
        // Back-pressure after first accept, then resume.
        vecs.push_back('{1'b0, 8'hFF, 3'd0, 1'b1, 2, 1'b0, 3'd0});
        vecs.push_back('{1'b1, 8'hFF, 3'd0, 1'b1, 2, 1'b1, 3'd0});
        for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 8'hFF, 3'd0, 1'b0, 2, 1'b1, 3'd0});
        for (int i = 1; i <= 3; i++) vecs.push_back('{1'b1, 8'hFF, 3'd0, 1'b1, 2, 1'b1, 3'(i)});
        // Sparse requests wrap between 7 and 0.
        for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 8'h81, 3'd0, 1'b1, 2, 1'b1, (i % 2 == 0) ? 3'd7 : 3'd0});
        run_vecs();

        // Asynchronous reset mid-cycle clears the output at once.
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("midrst_valid", int'(valid_d[2]), 0);
        chk("midrst_out", int'(out_d[2]), 0);
        @(negedge clk);
        vecs.push_back('{1'b0, 8'h81, 3'd0, 1'b1, 2, 1'b0, 3'd0});
        vecs.push_back('{1'b1, 8'h81, 3'd0, 1'b1, 2, 1'b1, 3'd0});
        // Fixed priority: lowest valid wins.
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b1, 8'hA4, 3'd0, 1'b1, 1, 1'b1, 3'd2});
        vecs.push_back('{1'b1, 8'hA0, 3'd0, 1'b1, 1, 1'b1, 3'd5});
        // Select mode follows the previous cycle's select.
        for (int i = 0; i < 10; i++) vecs.push_back('{1'b1, 8'hFF, 3'(i % 8), 1'b1, 0, 1'b1, 3'(i % 8)});
        run_vecs();

        // Randomised traffic, data and back-pressure against the model.
        for (int n = 0; n < 600; n++) begin
            in = C*W'($urandom);
            apply(($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                  3'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised, handshaked successor to the combinational `Mux`. It arbitrates among `CHANNELS = 2**SIZE` valid/ready input channels of `WIDTH` bits each and forwards one word per cycle into a single-entry output register. The arbitration mode is a parameter: software select, fixed priority or round-robin. The block sits wherever several producers share one downstream consumer and back-pressure must be honoured.

## Interface
- `WIDTH`, 3: data width per channel.
- `SIZE`, 3: select width; `CHANNELS = 2**SIZE`.
- `MODE`, `ARB_RR`: arbitration mode, of type `mux_pkg::arb_mode_t`:
  - `ARB_SELECT`: only the channel named by `select` is eligible.
  - `ARB_FIXED`: the lowest-index valid channel wins.
  - `ARB_RR`: round-robin.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `in`, in, `CHANNELS*WIDTH`: flat input data; channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_valid`, in, `CHANNELS`: per-channel valid.
- `in_ready`, out, `CHANNELS`: per-channel ready; at most one bit is high (one-hot or zero).
- `select`, in, `SIZE`: channel choice; used only in `ARB_SELECT` mode.
- `out`, out, `WIDTH`: registered output data.
- `out_chan`, out, `SIZE`: index of the channel that supplied `out`.
- `out_valid`, out, 1: the output register holds a word.
- `out_ready`, in, 1: the consumer accepts the word.

## Operation
- Handshake: a transfer occurs on a rising `clk` edge when valid and ready are both high.
- `take = !out_valid | out_ready`, meaning the register is empty or draining this cycle.
- `grant` is a one-hot vector chosen from the eligible channels with `in_valid` high:
  - `ARB_SELECT`: `grant[select]` if `in_valid[select]`.
  - `ARB_FIXED`: the lowest set index.
  - `ARB_RR`: the first set index at or after `ptr`, searching upward and wrapping from CHANNELS-1 to 0.
- `in_ready = take ? grant : 0`. This is combinational from `in_valid`, `select`, `out_ready`, `out_valid` and `ptr`.
- On an edge with `take` and some grant g:
  - `out` ← channel g data.
  - `out_chan` ← g.
  - `out_valid` ← 1.
  - `ARB_RR` only: `ptr` ← (g+1) mod CHANNELS, wrapping naturally at SIZE bits.
- On an edge with `take` and no grant: `out_valid` ← 0. `out` and `out_chan` hold their last values, and `ptr` holds.
- While `out_valid && !out_ready`:
  - `out` and `out_chan` remain stable.
  - All `in_ready` bits are 0.
- Drain and refill happen in the same cycle, giving full throughput of one word per cycle.
- The pointer advances only on an accepted transfer, never on a stalled request.
- Inputs are not required to hold valid once asserted. A channel that drops valid before being granted is simply skipped.
- A `select` change while the register is stalled has no effect until `take` is high.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): `out_valid`=0, `out`=0, `out_chan`=0, `ptr`=0. `in_ready`=0 because it is gated by reset.
- Latency: a word accepted at edge N appears on `out` with `out_valid` after edge N, i.e. one cycle.
- Reset asserted mid-transfer: the in-flight word is discarded, outputs take their reset values immediately, and no handshake completes while reset is low.
- First cycle after reset release: arbitration starts from channel 0.

## Structure
- `mux_pkg`:
  - `arb_mode_t` enum: `ARB_SELECT`, `ARB_FIXED`, `ARB_RR`.
  - `function automatic` index helpers for one-hot-to-binary conversion.
- Sub-module `rr_arbiter #(SIZE)`:
  - Inputs: `req`, `ptr`.
  - Output: one-hot `grant`.
  - Implementation: combinational double-width rotate-and-priority scheme.
  - Reused for `ARB_FIXED` with `ptr` tied to 0.
- `arb_mux` holds the output register, the `ptr` register and the mode mux.
- Existing `Mux_checker` is extended with handshake-stability assertions: `out` is stable under stall and `in_ready` is one-hot-or-zero.

## Test plan
All scenarios use WIDTH=3, SIZE=3 and channel i data = i, matching the existing Mux bench pattern.
- **Reset:** hold `reset`=0 for 3 cycles with all `in_valid`=FF → `out_valid`=0, `out`=0, `in_ready`=00 throughout; first grant after release is ch0.
- **Round-robin:** MODE=`ARB_RR`, all `in_valid`=FF, `out_ready`=1 → `out` sequence 0,1,…,7,0,1 on consecutive cycles, and `out_chan` equals `out`.
- **Fixed priority:** MODE=`ARB_FIXED`, `in_valid`=8'b1010_0100 → `out`=2 every cycle. Clear bit 2 → `out`=5 the next cycle.
- **Select mode:** MODE=`ARB_SELECT`, `in_valid`=FF, `select` stepping 0..7 → `out` equals the previous cycle's `select` for 10 cycles.
- **Back-pressure:** RR mode, `out_ready`=0 for 4 cycles after the first accept → `out`=0 held, `in_ready`=00, `ptr` frozen. Raise `out_ready` → sequence resumes 1,2,3 with no loss or duplication.
- **Sparse and wrap:** RR mode, `in_valid`=8'b1000_0001 → alternates 7,0,7,0. A mid-stream async reset returns `out_valid` to 0 within the same cycle, and the next grant is 0.
